// File: rtl/bcd_convert_iter_if.sv
// bcd_convert_iter_if: start/done handshake and result bus of the iterative
// binary-to-BCD converter. The master drives requests, the slave converts.
interface bcd_convert_iter_if #(
   parameter int N      = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [N-1:0]          decimal;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;

   modport master (output start, decimal, input busy, done, bcd, overflow);
   modport slave  (input start, decimal, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_convert_iter.sv
// bcd_convert_iter: iterative double-dabble (shift-add-3) binary-to-BCD
// converter, one input bit per clock, N cycles from capture to done.
// The raw result is decimal mod 10^DIGITS; overflow flags values that do not fit.
// Optional build macro: BCD_OVERFLOW_SAT_EN -- on overflow, bcd is loaded with
// all nines instead of the modulo result.
module bcd_convert_iter #(
   parameter int N      = 8,
   parameter int DIGITS = 3
) (
   input logic               clk,
   input logic               rst,
   bcd_convert_iter_if.slave bus
);
   localparam int AW = 4 * DIGITS;
   localparam int CW = $clog2(N + 1);
   // Wide enough for both the input and 10^DIGITS (10^D < 16^D).
   localparam int LW = N + AW + 1;

   function automatic logic [LW-1:0] pow10(input int d);
      logic [LW-1:0] p;
      p = LW'(1);
      for (int i = 0; i < d; i++) p = p * LW'(10);
      return p;
   endfunction

   // Largest value that fits; a constant compare that is never true when 10^DIGITS >= 2^N.
   localparam logic [LW-1:0] LIMIT = pow10(DIGITS) - LW'(1);

   function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = a;
      for (int k = 0; k < DIGITS; k++)
         if (a[4*k +: 4] >= 4'd5) r[4*k +: 4] = a[4*k +: 4] + 4'd3;
      return r;
   endfunction

`ifdef BCD_OVERFLOW_SAT_EN
   function automatic logic [AW-1:0] all_nines();
      logic [AW-1:0] r;
      r = '0;
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'd9;
      return r;
   endfunction
`endif

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t          state, state_nx;
   logic [N-1:0]    bin;
   logic [AW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic            ovf_q;
   logic [AW-1:0]   bcd_q;
   logic            ovf_out;
   logic            done_q;
   logic [AW-1:0]   acc_nx;
   logic [N-1:0]    bin_nx;
   logic [AW-1:0]   result;
   logic            accept;
   logic            last;

   // Next state, handshake decode and the adjust-then-shift step of one iteration.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      // The bit leaving the top digit is dropped, giving the mod-10^DIGITS result.
      {acc_nx, bin_nx} = {add3(acc), bin} << 1;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CW'(1)) begin
               last     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef BCD_OVERFLOW_SAT_EN
   assign result = ovf_q ? all_nines() : acc_nx;
`else
   assign result = acc_nx;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Capture, iterate, and publish the result only on the final iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin     <= '0;
         acc     <= '0;
         cnt     <= '0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_out <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last;
         if (accept) begin
            bin   <= bus.decimal;
            acc   <= '0;
            cnt   <= CW'(N);
            ovf_q <= ({{(LW-N){1'b0}}, bus.decimal} > LIMIT);
         end else if (state == SHIFT) begin
            bin <= bin_nx;
            acc <= acc_nx;
            cnt <= cnt - CW'(1);
         end
         if (last) begin
            bcd_q   <= result;
            ovf_out <= ovf_q;
         end
      end
   end

   assign bus.busy     = (state == SHIFT);
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.overflow = ovf_out;
endmodule

// File: tb/tb_bcd_convert_iter.sv
// tb_bcd_convert_iter: scoreboard bench for bcd_convert_iter with three
// configurations: N=8/DIGITS=3, N=8/DIGITS=2 (overflow) and N=17/DIGITS=6.
module tb_bcd_convert_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   bcd_convert_iter_if #(.N(8),  .DIGITS(3)) ba ();
   bcd_convert_iter_if #(.N(8),  .DIGITS(2)) bb ();
   bcd_convert_iter_if #(.N(17), .DIGITS(6)) bc ();

   bcd_convert_iter #(.N(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
   bcd_convert_iter #(.N(8),  .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
   bcd_convert_iter #(.N(17), .DIGITS(6)) dut_c (.clk(clk), .rst(rst), .bus(bc.slave));

   // Expected entries: bit 24 = overflow, bits 23:0 = packed BCD.
   logic [24:0] q_a[$];
   logic [24:0] q_b[$];
   logic [24:0] q_c[$];

`ifdef BCD_OVERFLOW_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // Reference: decimal digits by division, saturating when the build asks for it.
   function automatic logic [24:0] model(input longint v, input int digits);
      longint      lim;
      longint      m;
      logic [23:0] b;
      lim = 1;
      b   = '0;
      for (int k = 0; k < digits; k++) lim = lim * 10;
      m = v % lim;
      for (int k = 0; k < digits; k++) begin
         b[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
      if (SAT && v >= lim)
         for (int k = 0; k < digits; k++) b[4*k +: 4] = 4'd9;
      return {(v >= lim), b};
   endfunction

   task automatic test_reset();
      ba.start = 1'b0; ba.decimal = '0;
      bb.start = 1'b0; bb.decimal = '0;
      bc.start = 1'b0; bc.decimal = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (ba.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ba.busy); else passed++;
      total++; if (ba.done !== 1'b0) $display("FAIL reset_done: got %b want 0", ba.done); else passed++;
      total++; if (ba.bcd !== 12'h000) $display("FAIL reset_bcd: got %h want 000", ba.bcd); else passed++;
      total++; if (ba.overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ba.overflow); else passed++;
      total++; if (bc.bcd !== 24'h0) $display("FAIL reset_bcd_wide: got %h want 000000", bc.bcd); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int          cyc;
      int          busy_n;
      logic [24:0] exp;
      @(negedge clk);
      ba.decimal = 8'd255; ba.start = 1'b1; q_a.push_back(model(255, 3));
      @(negedge clk);
      ba.start = 1'b0; ba.decimal = 8'd0;
      cyc = 0; busy_n = 0;
      while (ba.done !== 1'b1 && cyc < 40) begin
         if (ba.busy === 1'b1) busy_n++;
         @(negedge clk); cyc++;
      end
      total++; if (ba.done !== 1'b1) $display("FAIL basic_done: got no done want done"); else passed++;
      total++; if (cyc !== 8) $display("FAIL basic_latency: got %0d want 8", cyc); else passed++;
      total++; if (busy_n !== 8) $display("FAIL basic_busy_len: got %0d want 8", busy_n); else passed++;
      exp = q_a.pop_front();
      total++; if (ba.bcd !== exp[11:0]) $display("FAIL basic_bcd: got %h want %h", ba.bcd, exp[11:0]); else passed++;
      total++; if (ba.overflow !== exp[24]) $display("FAIL basic_ovf: got %b want %b", ba.overflow, exp[24]); else passed++;
      @(negedge clk);
      total++; if (ba.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", ba.done); else passed++;
   endtask

   task automatic test_busy_protect();
      int          n_done;
      logic [11:0] got_bcd;
      logic        got_ovf;
      logic [24:0] exp;
      @(negedge clk);
      ba.decimal = 8'd42; ba.start = 1'b1; q_a.push_back(model(42, 3));
      @(negedge clk);
      ba.start = 1'b0;
      repeat (2) @(negedge clk);
      ba.decimal = 8'd200; ba.start = 1'b1;
      @(negedge clk);
      ba.start = 1'b0;
      n_done = 0; got_bcd = '0; got_ovf = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (ba.done === 1'b1) begin
            n_done++; got_bcd = ba.bcd; got_ovf = ba.overflow;
         end
      end
      total++; if (n_done !== 1) $display("FAIL busy_done_count: got %0d want 1", n_done); else passed++;
      exp = q_a.pop_front();
      total++; if (got_bcd !== exp[11:0]) $display("FAIL busy_bcd: got %h want %h", got_bcd, exp[11:0]); else passed++;
      total++; if (got_ovf !== exp[24]) $display("FAIL busy_ovf: got %b want %b", got_ovf, exp[24]); else passed++;
   endtask

   task automatic test_back_to_back();
      int          cyc;
      int          gap;
      int          busy_n;
      logic [24:0] exp;
      @(negedge clk);
      ba.decimal = 8'd59; ba.start = 1'b1; q_a.push_back(model(59, 3));
      @(negedge clk);
      ba.start = 1'b0;
      cyc = 0;
      while (ba.done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
      total++; if (ba.done !== 1'b1) $display("FAIL b2b_first_done: got no done want done"); else passed++;
      exp = q_a.pop_front();
      total++; if (ba.bcd !== exp[11:0]) $display("FAIL b2b_first_bcd: got %h want %h", ba.bcd, exp[11:0]); else passed++;
      ba.decimal = 8'd7; ba.start = 1'b1; q_a.push_back(model(7, 3));
      @(negedge clk);
      ba.start = 1'b0;
      gap = 0; busy_n = 0;
      while (ba.done !== 1'b1 && gap < 40) begin
         if (ba.busy === 1'b1) busy_n++;
         gap++;
         @(negedge clk);
      end
      total++; if (gap !== 8) $display("FAIL b2b_gap: got %0d want 8", gap); else passed++;
      total++; if (busy_n !== 8) $display("FAIL b2b_busy: got %0d want 8", busy_n); else passed++;
      exp = q_a.pop_front();
      total++; if (ba.bcd !== exp[11:0]) $display("FAIL b2b_second_bcd: got %h want %h", ba.bcd, exp[11:0]); else passed++;
   endtask

   task automatic test_reset_mid_op();
      int          n_done;
      int          cyc;
      logic [24:0] exp;
      @(negedge clk);
      ba.decimal = 8'd200; ba.start = 1'b1;
      @(negedge clk);
      ba.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (ba.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", ba.busy); else passed++;
      total++; if (ba.bcd !== 12'h000) $display("FAIL rstmid_bcd: got %h want 000", ba.bcd); else passed++;
      total++; if (ba.overflow !== 1'b0) $display("FAIL rstmid_ovf: got %b want 0", ba.overflow); else passed++;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         if (ba.done === 1'b1) n_done++;
         @(negedge clk);
      end
      total++; if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d want 0", n_done); else passed++;
      ba.decimal = 8'd200; ba.start = 1'b1; q_a.push_back(model(200, 3));
      @(negedge clk);
      ba.start = 1'b0;
      cyc = 0;
      while (ba.done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
      total++; if (ba.done !== 1'b1) $display("FAIL rstmid_redo_done: got no done want done"); else passed++;
      exp = q_a.pop_front();
      total++; if (ba.bcd !== exp[11:0]) $display("FAIL rstmid_redo_bcd: got %h want %h", ba.bcd, exp[11:0]); else passed++;
   endtask

   task automatic test_narrow_overflow();
      int          vals[3];
      int          cyc;
      logic [24:0] exp;
      vals = '{123, 99, 100};
      foreach (vals[i]) begin
         @(negedge clk);
         bb.decimal = 8'(vals[i]); bb.start = 1'b1; q_b.push_back(model(vals[i], 2));
         @(negedge clk);
         bb.start = 1'b0;
         cyc = 0;
         while (bb.done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
         total++; if (bb.done !== 1'b1) $display("FAIL narrow_done[%0d]: got no done want done", vals[i]); else passed++;
         exp = q_b.pop_front();
         total++; if (bb.bcd !== exp[7:0]) $display("FAIL narrow_bcd[%0d]: got %h want %h", vals[i], bb.bcd, exp[7:0]); else passed++;
         total++; if (bb.overflow !== exp[24]) $display("FAIL narrow_ovf[%0d]: got %b want %b", vals[i], bb.overflow, exp[24]); else passed++;
      end
   endtask

   task automatic test_wide();
      int          vals[3];
      int          cyc;
      logic [24:0] exp;
      vals = '{99999, 0, 131071};
      foreach (vals[i]) begin
         @(negedge clk);
         bc.decimal = 17'(vals[i]); bc.start = 1'b1; q_c.push_back(model(vals[i], 6));
         @(negedge clk);
         bc.start = 1'b0; bc.decimal = '1;
         cyc = 0;
         while (bc.done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
         total++; if (cyc !== 17) $display("FAIL wide_latency[%0d]: got %0d want 17", vals[i], cyc); else passed++;
         exp = q_c.pop_front();
         total++; if (bc.bcd !== exp[23:0]) $display("FAIL wide_bcd[%0d]: got %h want %h", vals[i], bc.bcd, exp[23:0]); else passed++;
         total++; if (bc.overflow !== exp[24]) $display("FAIL wide_ovf[%0d]: got %b want %b", vals[i], bc.overflow, exp[24]); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_protect();
      test_back_to_back();
      test_reset_mid_op();
      test_narrow_overflow();
      test_wide();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end
endmodule
